// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder. Operands are split into 4-bit lookahead groups, and GROUPS_PER_STAGE groups are resolved in each stage.
// Latency: STAGES cycles, where STAGES = ceil((WIDTH/4)/GROUPS_PER_STAGE). Throughput is one result per cycle.
// Backpressure: all stages advance together when !out_valid | out_ready, and in_ready follows that advance.
// Optional subtract port under `CLA_PIPE_SUB_EN (s = a - b, cout = not borrow).
module cla_pipe_adder #(
  parameter int WIDTH            = 16,
  parameter int GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NG     = WIDTH / 4;
  localparam int GPS    = GROUPS_PER_STAGE;
  localparam int STAGES = (NG + GPS - 1) / GPS;

  logic adv;
  logic sub_eff;

`ifdef CLA_PIPE_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  // The whole pipe moves in lockstep; the inter-stage bubbles are not squeezed out.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Computes the 4-bit lookahead carries. Bits [3:0] are the per-bit carry-ins, and bit 4 is the group carry-out.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic       gg;
    logic       pp;
    g     = x & y;
    p     = x ^ y;
    gg    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pp    = &p;
    cla4[0] = ci;
    cla4[1] = g[0] | (p[0] & ci);
    cla4[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    cla4[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    cla4[4] = gg | (pp & ci);
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * GPS;
    localparam int HI = ((k + 1) * GPS > NG) ? NG : (k + 1) * GPS;

    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] s_i;
    logic             c_i;
    logic             v_i;
    logic [WIDTH-1:0] s_nx;
    logic             c_nx;
    logic             cm_nx;
    logic             vld_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;

    if (k == 0) begin : g_src
      // When subtracting, the inverted B and the forced carry-in are folded in at this point. After that, the stored operand already encodes sub.
      assign a_i = a;
      assign b_i = sub_eff ? ~b : b;
      assign c_i = sub_eff ? 1'b1 : cin;
      assign s_i = '0;
      assign v_i = in_valid;
    end else begin : g_pipe
      assign a_i = stg[k-1].g_fwd.a_q;
      assign b_i = stg[k-1].g_fwd.b_q;
      assign c_i = stg[k-1].c_q;
      assign s_i = stg[k-1].s_q;
      assign v_i = stg[k-1].vld_q;
    end

    // Resolves this stage's groups. The group carry is chained through the lookahead G/P terms.
    always_comb begin
      logic [4:0] cv;
      logic       cc;
      cv    = '0;
      cc    = c_i;
      s_nx  = s_i;
      cm_nx = 1'b0;
      for (int gi = LO; gi < HI; gi++) begin
        cv                = cla4(a_i[gi*4 +: 4], b_i[gi*4 +: 4], cc);
        s_nx[gi*4 +: 4]   = a_i[gi*4 +: 4] ^ b_i[gi*4 +: 4] ^ cv[3:0];
        cm_nx             = cv[3];
        cc                = cv[4];
      end
      c_nx = cc;
    end

    // Stage register for valid, partial sum and carry. It holds while the pipe is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        s_q   <= '0;
        c_q   <= 1'b0;
      end else if (adv) begin
        vld_q <= v_i;
        s_q   <= s_nx;
        c_q   <= c_nx;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      // Forwards the operands for the groups that later stages still have to resolve.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_i;
          b_q <= b_i;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;
      // Signed overflow: the carry into the MSB differs from the carry out of the MSB.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= cm_nx ^ c_nx;
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].vld_q;
  assign s         = stg[STAGES-1].s_q;
  assign cout      = stg[STAGES-1].c_q;
  assign ovf       = stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder. Two instances run side by side: 16-bit with one group per stage, and 32-bit with three groups per stage.
// Each instance has a scoreboard that uses a plain arithmetic reference model, plus directed cases.
// Both instances share the handshake drive, so backpressure and reset apply to them together.
module tb_cla_pipe_adder;
  localparam int W0 = 16, G0 = 1, S0 = 4;
  localparam int W1 = 32, G1 = 3, S1 = 3;
`ifdef CLA_PIPE_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  typedef logic [33:0] res_t; // {ovf, cout, s[31:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [15:0] a0 = '0, b0 = '0;
  logic [31:0] a1 = '0, b1 = '0;
  logic        in_ready0, out_valid0, cout0, ovf0;
  logic [15:0] s0;
  logic        in_ready1, out_valid1, cout1, ovf1;
  logic [31:0] s1;

  int checks = 0;
  int errors = 0;
  res_t q0[$];
  res_t q1[$];
  logic pv0 = 1'b0, pv1 = 1'b0;
  logic [35:0] pr0, pr1;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W0), .GROUPS_PER_STAGE(G0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a0), .b(b0), .cin(cin),
`ifdef CLA_PIPE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid0), .out_ready(out_ready), .s(s0), .cout(cout0), .ovf(ovf0)
  );

  cla_pipe_adder #(.WIDTH(W1), .GROUPS_PER_STAGE(G1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin),
`ifdef CLA_PIPE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid1), .out_ready(out_ready), .s(s1), .cout(cout1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: add or subtract with plain integer arithmetic. Overflow is taken from the operand and result signs.
  function automatic res_t ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb);
    logic [31:0] mask, ye, sm;
    logic [32:0] full;
    logic        co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    ye   = (sb ? ~y : y) & mask;
    full = {1'b0, x & mask} + {1'b0, ye} + {32'h0, (sb ? 1'b1 : ci)};
    sm   = full[31:0] & mask;
    co   = full[w];
    ov   = (x[w-1] == ye[w-1]) && (sm[w-1] != x[w-1]);
    return {ov, co, sm};
  endfunction

  function automatic res_t pk0();
    return {ovf0, cout0, 16'h0, s0};
  endfunction

  function automatic res_t pk1();
    return {ovf1, cout1, s1};
  endfunction

  // Scoreboard and handshake-rule monitor. Transfers happen at the following rising edge.
  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      chk("rdy0_rule", in_ready0, !out_valid0 || out_ready);
      chk("rdy1_rule", in_ready1, !out_valid1 || out_ready);
      if (pv0) chk("hold0", {out_valid0, ovf0, cout0, 1'b0, s0}, {pr0[35:32], pr0[15:0]});
      if (pv1) chk("hold1", {out_valid1, ovf1, cout1, s1}, pr1[34:0]);
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) chk("spurious0", 1, 0);
        else begin e = q0.pop_front(); chk("res0", pk0(), e); end
      end
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) chk("spurious1", 1, 0);
        else begin e = q1.pop_front(); chk("res1", pk1(), e); end
      end
      if (in_valid && in_ready0) q0.push_back(ref_add(W0, {16'h0, a0}, {16'h0, b0}, cin, HAS_SUB & sub));
      if (in_valid && in_ready1) q1.push_back(ref_add(W1, a1, b1, cin, HAS_SUB & sub));
      pv0 = out_valid0 && !out_ready;
      pv1 = out_valid1 && !out_ready;
      pr0 = {out_valid0, ovf0, cout0, 1'b0, 16'h0, s0};
      pr1 = {1'b0, out_valid1, ovf1, cout1, s1};
    end else begin
      q0.delete();
      q1.delete();
      pv0 = 1'b0;
      pv1 = 1'b0;
    end
  end

  // Sends one transfer into an empty pipe, then measures latency and checks each result against a fixed expectation.
  task automatic run_one(input logic [15:0] x0, input logic [15:0] y0, input logic [31:0] x1,
                         input logic [31:0] y1, input logic ci, input logic sb,
                         input res_t e0, input res_t e1, input string tag);
    int l0, l1;
    @(posedge clk); #1;
    a0 = x0; b0 = y0; a1 = x1; b1 = y1; cin = ci; sub = sb;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l0 = 0; l1 = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (out_valid0 && l0 == 0) begin l0 = n; chk({tag, "_v0"}, pk0(), e0); end
      if (out_valid1 && l1 == 0) begin l1 = n; chk({tag, "_v1"}, pk1(), e1); end
    end
    chk({tag, "_lat0"}, l0, S0);
    chk({tag, "_lat1"}, l1, S1);
  endtask

  initial begin
    int first, last, cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_v0", out_valid0, 0); chk("rst_s0", s0, 0); chk("rst_c0", cout0, 0); chk("rst_o0", ovf0, 0);
    chk("rst_v1", out_valid1, 0); chk("rst_s1", s1, 0); chk("rst_r0", in_ready0, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_one(16'hFFFF, 16'h0001, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
            {1'b0, 1'b1, 32'h0}, {1'b0, 1'b1, 32'h0}, "wrap");
    run_one(16'h7FFF, 16'h0001, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
            {1'b1, 1'b0, 32'h8000}, {1'b1, 1'b0, 32'h8000_0000}, "ovfp");
    run_one(16'h8000, 16'h8000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0,
            {1'b1, 1'b1, 32'h1}, {1'b1, 1'b1, 32'h1}, "ovfn");
`ifdef CLA_PIPE_SUB_EN
    run_one(16'd5, 16'd7, 32'd5, 32'd7, 1'b0, 1'b1,
            {1'b0, 1'b0, 32'hFFFE}, {1'b0, 1'b0, 32'hFFFF_FFFE}, "sub");
`else
    run_one(16'd5, 16'd7, 32'd5, 32'd7, 1'b0, 1'b1,
            {1'b0, 1'b0, 32'd12}, {1'b0, 1'b0, 32'd12}, "subx");
`endif
    run_one(16'd5, 16'd7, 32'd5, 32'd7, 1'b0, 1'b0,
            {1'b0, 1'b0, 32'd12}, {1'b0, 1'b0, 32'd12}, "add");

    // Back-to-back: eight consecutive transfers that must come out as an unbroken run, in order.
    first = -1; last = -1; cnt = 0; out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
    for (int t = 0; t < 8 + S0 + 4; t++) begin
      @(posedge clk); #1;
      if (t < 8) begin
        in_valid = 1'b1; a0 = 16'(t); b0 = 16'(t * 32'h1000); a1 = 32'(t); b1 = 32'(t * 32'h1000);
      end else in_valid = 1'b0;
      @(negedge clk);
      if (t < 8) chk("b2b_rdy", in_ready0, 1);
      if (out_valid0) begin
        if (first < 0) first = t;
        last = t;
        chk("b2b_s", s0, 16'(cnt * 32'h1001));
        cnt++;
      end
    end
    chk("b2b_cnt", cnt, 8);
    chk("b2b_run", last - first + 1, 8);

    // Backpressure: fill with out_ready low, hold for 5 cycles, then drain.
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom); a1 = $urandom; b1 = $urandom; cin = 1'($urandom);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("bp_rdy0", in_ready0, 0); chk("bp_rdy1", in_ready1, 0); chk("bp_v0", out_valid0, 1);
      @(posedge clk); #1;
    end
    chk("bp_q0", q0.size(), S0);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("bp_drain0", q0.size(), 0); chk("bp_drain1", q1.size(), 0);

    // Reset mid-flight: the results in flight are dropped, and nothing emerges after release.
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom); a1 = $urandom; b1 = $urandom;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    chk("prerst_v0", out_valid0, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_v0", out_valid0, 0); chk("mrst_s0", s0, 0);
    chk("mrst_v1", out_valid1, 0); chk("mrst_s1", s1, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) cnt++;
    end
    chk("post_rst_stale", cnt, 0);

    // Random traffic with random backpressure, checked by the scoreboard.
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      a0 = 16'($urandom); b0 = 16'($urandom); a1 = $urandom; b1 = $urandom;
      cin = 1'($urandom); sub = 1'($urandom);
      if (t % 50 == 0) begin a0 = 16'hFFFF; b0 = 16'h0; a1 = 32'hFFFF_FFFF; b1 = 32'h0; cin = 1'b1; end
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("rnd_drain0", q0.size(), 0); chk("rnd_drain1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
